// File: rtl/window_sequencer_pkg.sv
// rtl/window_sequencer_pkg.sv - shared state encoding, phase order and mode constants for window_sequencer
package window_sequencer_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int WIN_W_DEF = 8;

    localparam logic [1:0] MODE_ENABLE    = 2'b00;
    localparam logic [1:0] MODE_CALIBRATE = 2'b01;

    localparam logic [2:0] PH_SEND   = 3'd0;
    localparam logic [2:0] PH_INCR   = 3'd1;
    localparam logic [2:0] PH_PAUSE  = 3'd2;
    localparam logic [2:0] PH_LISTEN = 3'd3;
    localparam logic [2:0] PH_NONE   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND   = 3'd1,
        INCR   = 3'd2,
        PAUSE  = 3'd3,
        LISTEN = 3'd4,
        WEND   = 3'd5,
        DONE   = 3'd6
    } state_t;

    function automatic state_t phase_state(input logic [1:0] ph);
        state_t s;
        case (ph)
            2'd0:    s = SEND;
            2'd1:    s = INCR;
            2'd2:    s = PAUSE;
            default: s = LISTEN;
        endcase
        return s;
    endfunction

    // First phase at or after 'first' whose duration is nonzero; WEND when none remain.
    function automatic state_t pick_phase(input logic [2:0] first, input logic [3:0] nonzero);
        state_t s;
        s = WEND;
        for (int i = 3; i >= 0; i--) begin
            if (3'(i) >= first && nonzero[2'(i)]) s = phase_state(2'(i));
        end
        return s;
    endfunction

endpackage

// File: rtl/window_sequencer_phase_timer.sv
// rtl/window_sequencer_phase_timer.sv - loadable down-counter with zero flag for phase timing
module window_sequencer_phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/window_sequencer.sv
// rtl/window_sequencer.sv - runs SEND/INCREASE/PAUSE/LISTEN windows from latched profile timing
module window_sequencer
    import window_sequencer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] window_send_time,
    input  logic [CNT_W-1:0] window_increase_time,
    input  logic [CNT_W-1:0] window_pause_time,
    input  logic [CNT_W-1:0] window_listen_time,
    input  logic [WIN_W-1:0] num_windows,
    input  logic             lfd_disable_before,
    input  logic             lfd_enable_after,
    input  logic             calibration_mode,
    input  logic             pause_action_required,
    output logic             busy,
    output logic             send_en,
    output logic             ramp_en,
    output logic             pause_en,
    output logic             listen_en,
    output logic             lfd_off,
    output logic             pause_action,
    output logic             calib_sample,
    output logic             window_done,
    output logic [WIN_W-1:0] window_idx,
    output logic             done,
    output logic             aborted
);

    state_t state, state_next;

    logic [CNT_W-1:0] lat_send, lat_incr, lat_pause, lat_listen;
    logic [CNT_W-1:0] src_send, src_incr, src_pause, src_listen;
    logic [WIN_W-1:0] lat_num;
    logic             lat_disable, lat_enable_after, lat_calib, lat_pause_req;
    logic [3:0]       nonzero;
    logic             start_accept, win_adv, window_start, disable_src, lfd_next;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0] tmr_value, tmr_count;

    window_sequencer_phase_timer #(.W(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (tmr_load),
        .load_value (tmr_value),
        .dec        (tmr_dec),
        .count      (tmr_count),
        .zero       (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // In IDLE the live inputs drive phase selection so the first phase starts the cycle after start.
    always_comb begin
        src_send     = (state == IDLE) ? window_send_time     : lat_send;
        src_incr     = (state == IDLE) ? window_increase_time : lat_incr;
        src_pause    = (state == IDLE) ? window_pause_time    : lat_pause;
        src_listen   = (state == IDLE) ? window_listen_time   : lat_listen;
        nonzero      = {src_listen != '0, src_pause != '0, src_incr != '0, src_send != '0};
        state_next   = state;
        start_accept = 1'b0;
        win_adv      = 1'b0;
        if (state != IDLE && abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (start && !abort) begin
                    start_accept = 1'b1;
                    state_next   = (num_windows == '0) ? DONE : pick_phase(PH_SEND, nonzero);
                end
                SEND:   if (tmr_zero) state_next = pick_phase(PH_INCR, nonzero);
                INCR:   if (tmr_zero) state_next = pick_phase(PH_PAUSE, nonzero);
                PAUSE:  if (tmr_zero) state_next = pick_phase(PH_LISTEN, nonzero);
                LISTEN: if (tmr_zero) state_next = pick_phase(PH_NONE, nonzero);
                WEND: begin
                    if (window_idx == lat_num - WIN_W'(1)) begin
                        state_next = DONE;
                    end else begin
                        win_adv    = 1'b1;
                        state_next = pick_phase(PH_SEND, nonzero);
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        tmr_load  = (state_next != state) && (state_next inside {SEND, INCR, PAUSE, LISTEN});
        tmr_dec   = (state inside {SEND, INCR, PAUSE, LISTEN}) && !tmr_zero;
        case (state_next)
            SEND:    tmr_value = src_send - CNT_W'(1);
            INCR:    tmr_value = src_incr - CNT_W'(1);
            PAUSE:   tmr_value = src_pause - CNT_W'(1);
            LISTEN:  tmr_value = src_listen - CNT_W'(1);
            default: tmr_value = '0;
        endcase
    end

    // A window start that forces LFD off wins over the release from the preceding WEND.
    always_comb begin
        window_start = (start_accept && num_windows != '0) || win_adv;
        disable_src  = (state == IDLE) ? lfd_disable_before : lat_disable;
        lfd_next     = lfd_off;
        if (state_next == IDLE) begin
            lfd_next = 1'b0;
        end else begin
            if (state == WEND && lat_enable_after) lfd_next = 1'b0;
            if (window_start && disable_src) lfd_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_send         <= '0;
            lat_incr         <= '0;
            lat_pause        <= '0;
            lat_listen       <= '0;
            lat_num          <= '0;
            lat_disable      <= 1'b0;
            lat_enable_after <= 1'b0;
            lat_calib        <= 1'b0;
            lat_pause_req    <= 1'b0;
            window_idx       <= '0;
            lfd_off          <= 1'b0;
            aborted          <= 1'b0;
        end else begin
            if (start_accept) begin
                lat_send         <= window_send_time;
                lat_incr         <= window_increase_time;
                lat_pause        <= window_pause_time;
                lat_listen       <= window_listen_time;
                lat_num          <= num_windows;
                lat_disable      <= lfd_disable_before;
                lat_enable_after <= lfd_enable_after;
                lat_calib        <= calibration_mode;
                lat_pause_req    <= pause_action_required;
                window_idx       <= '0;
            end else if (win_adv) begin
                window_idx <= window_idx + WIN_W'(1);
            end
            lfd_off <= lfd_next;
            aborted <= (state != IDLE) && abort;
        end
    end

    assign busy         = (state != IDLE);
    assign send_en      = (state == SEND);
    assign ramp_en      = (state == INCR);
    assign pause_en     = (state == PAUSE);
    assign listen_en    = (state == LISTEN);
    assign window_done  = (state == WEND);
    assign done         = (state == DONE);
    assign pause_action = (state == PAUSE) && lat_pause_req && (tmr_count == lat_pause - CNT_W'(1));
    assign calib_sample = (state == LISTEN) && lat_calib && tmr_zero;

endmodule

// File: tb/tb_window_sequencer.sv
// tb/tb_window_sequencer.sv - scoreboard bench for window_sequencer
module tb_window_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0;
    logic [15:0] window_send_time = '0, window_increase_time = '0;
    logic [15:0] window_pause_time = '0, window_listen_time = '0;
    logic [7:0]  num_windows = '0;
    logic        lfd_disable_before = 1'b0, lfd_enable_after = 1'b0;
    logic        calibration_mode = 1'b0, pause_action_required = 1'b0;
    logic        busy, send_en, ramp_en, pause_en, listen_en, lfd_off;
    logic        pause_action, calib_sample, window_done, done, aborted;
    logic [7:0]  window_idx;

    typedef struct packed {
        logic       busy, send, ramp, pause, listen, lfd, pa, cs, wd, done, aborted;
        logic [7:0] idx;
    } obs_t;

    obs_t sb[$];
    obs_t exp_v, got_v;
    int   n_cmp = 0, n_err = 0, cyc;
    logic [7:0] exp_idx = '0;

    window_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .window_send_time(window_send_time), .window_increase_time(window_increase_time),
        .window_pause_time(window_pause_time), .window_listen_time(window_listen_time),
        .num_windows(num_windows), .lfd_disable_before(lfd_disable_before),
        .lfd_enable_after(lfd_enable_after), .calibration_mode(calibration_mode),
        .pause_action_required(pause_action_required),
        .busy(busy), .send_en(send_en), .ramp_en(ramp_en), .pause_en(pause_en),
        .listen_en(listen_en), .lfd_off(lfd_off), .pause_action(pause_action),
        .calib_sample(calib_sample), .window_done(window_done), .window_idx(window_idx),
        .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    function automatic obs_t observe();
        obs_t o;
        o.busy = busy; o.send = send_en; o.ramp = ramp_en; o.pause = pause_en;
        o.listen = listen_en; o.lfd = lfd_off; o.pa = pause_action; o.cs = calib_sample;
        o.wd = window_done; o.done = done; o.aborted = aborted; o.idx = window_idx;
        return o;
    endfunction

    function automatic obs_t idle_vec(input logic [7:0] idx);
        obs_t o;
        o = '0;
        o.idx = idx;
        return o;
    endfunction

    // Expected per-cycle outputs from cycle k+1 on, ending with one idle cycle.
    task automatic expect_run(input int s, i, p, l, n, input bit dis, ena, cal, par);
        obs_t e;
        bit   lfd;
        int   d[4];
        lfd = 1'b0;
        d = '{s, i, p, l};
        if (n == 0) begin
            e = '0; e.busy = 1'b1; e.done = 1'b1; sb.push_back(e);
            exp_idx = '0;
        end else begin
            for (int w = 0; w < n; w++) begin
                if (w > 0 && ena) lfd = 1'b0;
                if (dis) lfd = 1'b1;
                for (int ph = 0; ph < 4; ph++) begin
                    for (int t = 0; t < d[ph]; t++) begin
                        e = '0; e.busy = 1'b1; e.idx = 8'(w); e.lfd = lfd;
                        case (ph)
                            0:       e.send = 1'b1;
                            1:       e.ramp = 1'b1;
                            2:       e.pause = 1'b1;
                            default: e.listen = 1'b1;
                        endcase
                        e.pa = (ph == 2 && t == 0 && par);
                        e.cs = (ph == 3 && t == d[ph] - 1 && cal);
                        sb.push_back(e);
                    end
                end
                e = '0; e.busy = 1'b1; e.wd = 1'b1; e.idx = 8'(w); e.lfd = lfd;
                sb.push_back(e);
            end
            if (ena) lfd = 1'b0;
            e = '0; e.busy = 1'b1; e.done = 1'b1; e.idx = 8'(n - 1); e.lfd = lfd;
            sb.push_back(e);
            exp_idx = 8'(n - 1);
        end
        sb.push_back(idle_vec(exp_idx));
    endtask

    task automatic start_run(input int s, i, p, l, n, input bit dis, ena, cal, par);
        @(negedge clk);
        window_send_time = 16'(s); window_increase_time = 16'(i);
        window_pause_time = 16'(p); window_listen_time = 16'(l);
        num_windows = 8'(n);
        lfd_disable_before = dis; lfd_enable_after = ena;
        calibration_mode = cal; pause_action_required = par;
        expect_run(s, i, p, l, n, dis, ena, cal, par);
        start = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        got_v = observe();
        if (got_v !== '0) begin
            n_err++;
            $display("FAIL reset_state got %h expected %h", got_v, obs_t'('0));
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        start_run(2, 3, 1, 2, 2, 0, 0, 0, 0);
        while (sb.size() != 0) begin
            @(negedge clk); start = 1'b0; cyc++;
            exp_v = sb.pop_front(); got_v = observe(); n_cmp++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL basic cycle k+%0d got %h expected %h", cyc, got_v, exp_v);
            end
        end
    endtask

    task automatic test_calibration();
        start_run(2, 3, 1, 2, 3, 1, 1, 1, 1);
        while (sb.size() != 0) begin
            @(negedge clk); start = 1'b0; cyc++;
            exp_v = sb.pop_front(); got_v = observe(); n_cmp++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL calib cycle k+%0d got %h expected %h", cyc, got_v, exp_v);
            end
        end
    endtask

    task automatic test_zero_cases();
        int cfg[4][9];
        cfg = '{'{2, 3, 1, 2, 0, 1, 1, 1, 1}, '{0, 0, 0, 0, 4, 1, 0, 1, 1},
                '{2, 0, 1, 2, 2, 0, 0, 0, 1}, '{1, 2, 0, 0, 2, 1, 1, 1, 1}};
        for (int c = 0; c < 4; c++) begin
            start_run(cfg[c][0], cfg[c][1], cfg[c][2], cfg[c][3], cfg[c][4],
                      cfg[c][5] != 0, cfg[c][6] != 0, cfg[c][7] != 0, cfg[c][8] != 0);
            while (sb.size() != 0) begin
                @(negedge clk); start = 1'b0; cyc++;
                exp_v = sb.pop_front(); got_v = observe(); n_cmp++;
                if (got_v !== exp_v) begin
                    n_err++;
                    $display("FAIL zero_case%0d cycle k+%0d got %h expected %h", c, cyc, got_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_abort();
        obs_t e;
        start_run(2, 3, 1, 2, 3, 1, 0, 1, 1);
        while (sb.size() > 13) void'(sb.pop_back());
        e = idle_vec(8'd1); e.aborted = 1'b1;
        sb.push_back(e);
        sb.push_back(idle_vec(8'd1));
        exp_idx = 8'd1;
        while (sb.size() != 0) begin
            @(negedge clk); start = 1'b0; cyc++;
            abort = (cyc == 13);
            exp_v = sb.pop_front(); got_v = observe(); n_cmp++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL abort cycle k+%0d got %h expected %h", cyc, got_v, exp_v);
            end
        end
        abort = 1'b0;
        test_basic();
    endtask

    task automatic test_abort_idle();
        for (int m = 0; m < 2; m++) begin
            @(negedge clk);
            window_send_time = 16'd2; num_windows = 8'd2;
            start = (m == 0); abort = 1'b1;
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            got_v = observe(); n_cmp++;
            if (got_v !== idle_vec(exp_idx)) begin
                n_err++;
                $display("FAIL abort_idle%0d got %h expected %h", m, got_v, idle_vec(exp_idx));
            end
        end
    endtask

    task automatic test_config_latch();
        start_run(2, 3, 1, 2, 2, 0, 0, 0, 0);
        while (sb.size() != 0) begin
            @(negedge clk); start = 1'b0; cyc++;
            if (cyc == 3) begin
                num_windows = 8'd5; window_send_time = 16'd7; window_increase_time = 16'd0;
                window_pause_time = 16'd7; window_listen_time = 16'd7;
                lfd_disable_before = 1'b1; calibration_mode = 1'b1; pause_action_required = 1'b1;
                start = 1'b1;
            end
            exp_v = sb.pop_front(); got_v = observe(); n_cmp++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL latch cycle k+%0d got %h expected %h", cyc, got_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_listen();
        start_run(2, 3, 1, 2, 2, 1, 1, 1, 1);
        while (cyc < 7) begin
            @(negedge clk); start = 1'b0; cyc++;
            exp_v = sb.pop_front(); got_v = observe(); n_cmp++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL rst_listen cycle k+%0d got %h expected %h", cyc, got_v, exp_v);
            end
        end
        sb.delete();
        #2 rst_n = 1'b0;
        #1 got_v = observe(); n_cmp++;
        if (got_v !== '0) begin
            n_err++;
            $display("FAIL rst_async got %h expected %h", got_v, obs_t'('0));
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (j == 2) rst_n = 1'b1;
            #1 got_v = observe(); n_cmp++;
            if (got_v !== '0) begin
                n_err++;
                $display("FAIL rst_hold%0d got %h expected %h", j, got_v, obs_t'('0));
            end
        end
        @(negedge clk);
        got_v = observe(); n_cmp++;
        if (got_v !== '0) begin
            n_err++;
            $display("FAIL rst_release got %h expected %h", got_v, obs_t'('0));
        end
        exp_idx = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_calibration();
        test_zero_cases();
        test_abort();
        test_abort_idle();
        test_config_latch();
        test_reset_mid_listen();
        test_basic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
